// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Holds the stage record type, the register-file select code and the default availability points.
package hazard_fwd_ctrl_pkg;

  localparam int HFC_NREGS      = 8;
  localparam int HFC_RW         = $clog2(HFC_NREGS);
  localparam int FWD_REGFILE    = 0;
  localparam int ALU_AVAIL_DEF  = 2;
  localparam int LOAD_AVAIL_DEF = 3;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic              mem;
    logic [HFC_RW-1:0] dst;
  } stage_rec_t;

endpackage

// File: rtl/hazard_fwd_ctrl_src_match.sv
// Youngest-writer search for one decode source operand.
// Returns the forwarding stage, or flags the source as blocked when that writer's result is not yet available.
module hfc_src_match
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int ALU_AVAIL  = ALU_AVAIL_DEF,
  parameter int LOAD_AVAIL = LOAD_AVAIL_DEF,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                   i_src_used,
  input  logic [HFC_RW-1:0]      i_src,
  input  stage_rec_t [DEPTH-1:0] i_recs,
  output logic [SELW-1:0]        o_sel,
  output logic                   o_blocked
);

  always_comb begin
    o_sel     = SELW'(FWD_REGFILE);
    o_blocked = 1'b0;
    // Walk oldest to youngest so the youngest matching writer decides the result.
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_src_used && i_recs[k-1].valid && i_recs[k-1].wr && (i_recs[k-1].dst == i_src)) begin
        if (k >= (i_recs[k-1].load ? LOAD_AVAIL : ALU_AVAIL)) begin
          o_sel     = SELW'(k);
          o_blocked = 1'b0;
        end else begin
          o_sel     = SELW'(FWD_REGFILE);
          o_blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline interlock controller: tracks DEPTH in-flight stage records and drives stall/bubble/hold/flush and forwarding selects.
// Optional HFC_PERF_EN adds 16-bit saturating perf counters for bubble, hold and flush.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int NREGS      = HFC_NREGS,
  parameter int NSRC       = 2,
  parameter int ALU_AVAIL  = ALU_AVAIL_DEF,
  parameter int LOAD_AVAIL = LOAD_AVAIL_DEF,
  parameter int MEM_STAGE  = 2,
  parameter int RW         = $clog2(NREGS),
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [RW-1:0]        id_dst,
  input  logic                 id_wr,
  input  logic                 id_load,
  input  logic                 id_store,
  input  logic                 id_branch,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic                 bubble,
  output logic                 hold,
  output logic                 flush,
  output logic [DEPTH-1:0]     stage_valid
`ifdef HFC_PERF_EN
  ,
  output logic [15:0]          perf_stall,
  output logic [15:0]          perf_hold,
  output logic [15:0]          perf_flush
`endif
);

  stage_rec_t [DEPTH-1:0] r_rec;
  stage_rec_t             w_dec;
  logic [NSRC-1:0]        w_blocked;
  logic                   w_hold;
  logic                   w_stall;

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.wr    = id_wr;
    w_dec.load  = id_load;
    w_dec.mem   = id_load | id_store;
    w_dec.dst   = id_dst;
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hfc_src_match #(
      .DEPTH      (DEPTH),
      .ALU_AVAIL  (ALU_AVAIL),
      .LOAD_AVAIL (LOAD_AVAIL),
      .SELW       (SELW)
    ) u_match (
      .i_src_used (id_src_used[g]),
      .i_src      (id_src[g*RW +: RW]),
      .i_recs     (r_rec),
      .o_sel      (fwd_sel[g*SELW +: SELW]),
      .o_blocked  (w_blocked[g])
    );
  end

  // Priority: memory hold over hazard stall over branch flush.
  assign w_hold  = r_rec[MEM_STAGE-1].valid & r_rec[MEM_STAGE-1].mem & ~mem_ready;
  assign w_stall = w_hold | (id_valid & (|w_blocked));
  assign hold    = w_hold;
  assign stall   = w_stall;
  assign bubble  = w_stall & ~w_hold;
  assign flush   = id_valid & id_branch & branch_taken & ~w_stall & ~reset;

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < DEPTH; k++) stage_valid[k] = r_rec[k].valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rec <= '0;
    end else if (!w_hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) r_rec[k] <= r_rec[k-1];
      r_rec[0] <= (id_valid && !w_stall) ? w_dec : '0;
    end
  end

`ifdef HFC_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_hold;
  logic [15:0] r_perf_flush;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_hold  <= '0;
      r_perf_flush <= '0;
    end else begin
      if (bubble) r_perf_stall <= sat_inc(r_perf_stall);
      if (hold)   r_perf_hold  <= sat_inc(r_perf_hold);
      if (flush)  r_perf_flush <= sat_inc(r_perf_flush);
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_hold  = r_perf_hold;
  assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: queue-based pipeline model plus directed and random decode streams.
module tb_hazard_fwd_ctrl;

  localparam int DEPTH = 3;
  localparam int NSRC  = 2;
  localparam int RW    = 3;
  localparam int SELW  = 2;
  localparam int ALU   = 2;
  localparam int LOAD  = 3;
  localparam int MEMS  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 id_valid;
  logic [NSRC*RW-1:0]   id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [RW-1:0]        id_dst;
  logic                 id_wr, id_load, id_store, id_branch, branch_taken, mem_ready;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall, bubble, hold, flush;
  logic [DEPTH-1:0]     stage_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit v;
    bit wr;
    bit ld;
    bit mem;
    int dst;
  } mrec_t;

  mrec_t pipe[$];   // pipe[0] is stage 1 (EX)
  int    e_sel[NSRC];
  bit    e_stall, e_bubble, e_hold, e_flush;

  hazard_fwd_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dst       (id_dst),
    .id_wr        (id_wr),
    .id_load      (id_load),
    .id_store     (id_store),
    .id_branch    (id_branch),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .bubble       (bubble),
    .hold         (hold),
    .flush        (flush),
    .stage_valid  (stage_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mrec_t z;
    z = '{0, 0, 0, 0, 0};
    pipe.delete();
    repeat (DEPTH) pipe.push_back(z);
  endtask

  task automatic model_outputs();
    bit any_blk;
    any_blk = 0;
    for (int i = 0; i < NSRC; i++) begin
      int s;
      s = int'(id_src[i*RW +: RW]);
      e_sel[i] = 0;
      if (id_src_used[i]) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (pipe[k-1].v && pipe[k-1].wr && pipe[k-1].dst == s) begin
            if (k >= (pipe[k-1].ld ? LOAD : ALU)) e_sel[i] = k;
            else any_blk = 1;
            break;
          end
        end
      end
    end
    e_hold   = pipe[MEMS-1].v && pipe[MEMS-1].mem && !mem_ready;
    e_stall  = e_hold || (id_valid && any_blk);
    e_bubble = e_stall && !e_hold;
    e_flush  = id_valid && id_branch && branch_taken && !e_stall && !reset;
  endtask

  task automatic cmp();
    int exp_sv;
    model_outputs();
    exp_sv = 0;
    for (int k = 0; k < DEPTH; k++) if (pipe[k].v) exp_sv |= (1 << k);
    for (int i = 0; i < NSRC; i++)
      chk($sformatf("model_fwd_sel%0d", i), int'(fwd_sel[i*SELW +: SELW]), e_sel[i]);
    chk("model_stall", int'(stall), int'(e_stall));
    chk("model_bubble", int'(bubble), int'(e_bubble));
    chk("model_hold", int'(hold), int'(e_hold));
    chk("model_flush", int'(flush), int'(e_flush));
    chk("model_stage_valid", int'(stage_valid), exp_sv);
  endtask

  task automatic at_neg();
    @(negedge clk);
    cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    model_outputs();
    if (reset) begin
      model_reset();
    end else if (!e_hold) begin
      mrec_t n;
      n = '{0, 0, 0, 0, 0};
      if (id_valid && !e_stall) n = '{1, id_wr, id_load, id_load || id_store, int'(id_dst)};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  task automatic dec(input bit v, input int s0, input int s1, input bit [1:0] used, input int dst,
                     input bit wr, input bit ld, input bit st, input bit br, input bit tk);
    id_valid     = v;
    id_src       = {RW'(s1), RW'(s0)};
    id_src_used  = used;
    id_dst       = RW'(dst);
    id_wr        = wr;
    id_load      = ld;
    id_store     = st;
    id_branch    = br;
    branch_taken = tk;
  endtask

  task automatic nop();
    dec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (DEPTH) begin
      at_neg();
      adv();
    end
  endtask

  function automatic int sel0();
    return int'(fwd_sel[SELW-1:0]);
  endfunction

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    nop();
    model_reset();
    at_neg();
    chk("rst_stage_valid", int'(stage_valid), 0);
    chk("rst_stall", int'(stall), 0);
    adv();
    adv();
    reset = 1'b0;

    // ALU -> dependent
    dec(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0); at_neg(); adv();
    dec(1, 1, 0, 2'b01, 2, 1, 0, 0, 0, 0);
    at_neg();
    chk("alu_stall", int'(stall), 1);
    chk("alu_bubble", int'(bubble), 1);
    chk("alu_sel_blocked", sel0(), 0);
    adv();
    at_neg();
    chk("alu_sel_fwd", sel0(), 2);
    chk("alu_stall_clear", int'(stall), 0);
    adv();
    drain();

    // Load -> dependent
    dec(1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0); at_neg(); adv();
    dec(1, 3, 0, 2'b01, 4, 1, 0, 0, 0, 0);
    at_neg(); chk("lu_stall1", int'(stall), 1); adv();
    at_neg(); chk("lu_stall2", int'(stall), 1); chk("lu_rec1_inv1", int'(stage_valid[0]), 0); adv();
    at_neg();
    chk("lu_sel", sel0(), 3);
    chk("lu_stall_clear", int'(stall), 0);
    chk("lu_rec1_inv2", int'(stage_valid[0]), 0);
    adv();
    drain();

    // Youngest writer wins; unused source never matches
    dec(1, 0, 0, 2'b00, 2, 1, 0, 0, 0, 0); at_neg(); adv(); at_neg(); adv();
    nop(); at_neg(); adv();
    dec(1, 2, 0, 2'b01, 5, 1, 0, 0, 0, 0);
    at_neg();
    chk("yw_sel", sel0(), 2);
    chk("yw_stall", int'(stall), 0);
    id_src_used = 2'b00;
    #1;
    cmp();
    chk("yw_unused_sel", sel0(), 0);
    chk("yw_unused_stall", int'(stall), 0);
    adv();
    drain();

    // Memory wait with a taken branch waiting in decode
    dec(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0); at_neg(); adv();
    nop(); at_neg(); adv();
    mem_ready = 1'b0;
    dec(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
    repeat (3) begin
      at_neg();
      chk("mw_hold", int'(hold), 1);
      chk("mw_stall", int'(stall), 1);
      chk("mw_bubble", int'(bubble), 0);
      chk("mw_flush", int'(flush), 0);
      chk("mw_frozen", int'(stage_valid), 2);
      adv();
    end
    mem_ready = 1'b1;
    at_neg();
    chk("mw_release_flush", int'(flush), 1);
    chk("mw_release_hold", int'(hold), 0);
    adv();
    nop();
    at_neg(); chk("mw_flush_once", int'(flush), 0); adv();
    drain();

    // Branch blocked by ALU writer in EX
    dec(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0); at_neg(); adv();
    dec(1, 4, 0, 2'b01, 0, 0, 0, 0, 1, 1);
    at_neg();
    chk("br_stall", int'(stall), 1);
    chk("br_no_flush", int'(flush), 0);
    adv();
    at_neg();
    chk("br_flush", int'(flush), 1);
    chk("br_sel", sel0(), 2);
    adv();
    drain();

    // Asynchronous reset in the middle of a hold
    dec(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0); at_neg(); adv();
    dec(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0); at_neg(); adv();
    dec(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0); at_neg(); adv();
    nop();
    mem_ready = 1'b0;
    at_neg();
    chk("rs_pre_hold", int'(hold), 1);
    chk("rs_pre_valid", int'(stage_valid), 7);
    #2 reset = 1'b1;
    dec(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
    #1;
    model_reset();
    cmp();
    chk("rs_stage_valid", int'(stage_valid), 0);
    chk("rs_hold", int'(hold), 0);
    chk("rs_stall", int'(stall), 0);
    chk("rs_flush", int'(flush), 0);
    adv();
    reset     = 1'b0;
    mem_ready = 1'b1;
    dec(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0); at_neg(); adv();
    nop();
    at_neg(); chk("rs_after1", int'(stage_valid), 1); adv();
    at_neg(); chk("rs_after2", int'(stage_valid), 2); adv();
    drain();

    // Random decode stream
    repeat (2000) begin
      int r;
      r = int'($urandom_range(0, 3));
      dec(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8), 2'($urandom % 4),
          int'($urandom % 8), 1'($urandom % 2), r == 1, r == 2, 1'($urandom % 2), 1'($urandom % 2));
      mem_ready = ($urandom % 4) != 0;
      at_neg();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
